// File: rtl/line_gen_pkg.sv
// Shared types and constants for the line generator.
package line_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Bit positions inside cfg_mode.
  localparam int unsigned MODE_CONT = 0;
  localparam int unsigned MODE_SAT  = 1;

endpackage

// File: rtl/line_gen_if.sv
// Output sample stream: valid/ready handshake carrying y and the x that produced it.
interface line_gen_if #(
  parameter int unsigned X_W = 16,
  parameter int unsigned Y_W = 32
) ();

  logic [Y_W-1:0] y;
  logic [X_W-1:0] x_out;
  logic           y_valid;
  logic           y_ready;

  modport master (output y, output x_out, output y_valid, input y_ready);
  modport slave  (input y, input x_out, input y_valid, output y_ready);

endinterface

// File: rtl/line_gen_mac.sv
// Two-stage multiply/add pipe: stage 1 forms m*x, stage 2 adds c and applies
// saturate/wrap. Both stages move together on advance; flush empties them.
module line_gen_mac #(
  parameter int unsigned COEF_W = 8,
  parameter int unsigned X_W    = 16,
  parameter int unsigned Y_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              advance,
  input  logic              flush,
  input  logic              sat,
  input  logic [COEF_W-1:0] m,
  input  logic [COEF_W-1:0] c,
  input  logic              in_valid,
  input  logic [X_W-1:0]    in_x,
  input  logic              in_last,
  output logic              out_valid,
  output logic [X_W-1:0]    out_x,
  output logic              out_last,
  output logic [Y_W-1:0]    y
);

  localparam int unsigned P_W = COEF_W + X_W;
  localparam int unsigned S_W = P_W + 1;
  // Wide enough to hold both the sum and the output, so the overflow test
  // degenerates to constant 0 when Y_W covers the full sum.
  localparam int unsigned E_W = (S_W > Y_W) ? S_W : Y_W;

  logic           s1_valid;
  logic           s1_last;
  logic [X_W-1:0] s1_x;
  logic [P_W-1:0] s1_p;
  logic [S_W-1:0] sum;
  logic [E_W-1:0] sum_ext;
  logic           ovf;
  logic [Y_W-1:0] y_d;

  // Stage-2 arithmetic: add offset, detect overflow of the output width.
  always_comb begin
    sum     = S_W'(s1_p) + S_W'(c);
    sum_ext = E_W'(sum);
    ovf     = (sum_ext >> Y_W) != '0;
    y_d     = (sat && ovf) ? '1 : sum_ext[Y_W-1:0];
  end

  // Pipeline registers; they hold while advance is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_x      <= '0;
      s1_p      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_x     <= '0;
      y         <= '0;
    end else if (ce && flush) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s1_last   <= in_last;
      s1_x      <= in_x;
      s1_p      <= P_W'(m) * P_W'(in_x);
      out_valid <= s1_valid;
      out_last  <= s1_valid & s1_last;
      if (s1_valid) begin
        out_x <= s1_x;
        y     <= y_d;
      end
    end
  end

endmodule

// File: rtl/line_gen.sv
// Straight-line sample generator: sweeps x from cfg_x0 by cfg_xstep up to
// cfg_xlast and streams y = m*x + c through a 2-stage pipe.
module line_gen
  import line_gen_pkg::*;
#(
  parameter int unsigned COEF_W = 8,
  parameter int unsigned X_W    = 16,
  parameter int unsigned Y_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              cfg_load,
  input  logic [COEF_W-1:0] cfg_m,
  input  logic [COEF_W-1:0] cfg_c,
  input  logic [X_W-1:0]    cfg_x0,
  input  logic [X_W-1:0]    cfg_xstep,
  input  logic [X_W-1:0]    cfg_xlast,
  input  logic [1:0]        cfg_mode,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  line_gen_if.master        stream
);

  state_t            state;
  logic [COEF_W-1:0] m_q;
  logic [COEF_W-1:0] c_q;
  logic [X_W-1:0]    x0_q;
  logic [X_W-1:0]    step_q;
  logic [X_W-1:0]    xlast_q;
  logic [1:0]        mode_q;
  logic [X_W-1:0]    x_q;

  logic              advance;
  logic              xfer;
  logic              issue_valid;
  logic              issue_last;
  logic [X_W-1:0]    issue_x;
  logic [X_W-1:0]    step_eff;
  logic [X_W-1:0]    next_x;
  logic [X_W:0]      x_sum;
  logic              out_valid;
  logic              out_last;
  logic [X_W-1:0]    out_x;
  logic [Y_W-1:0]    out_y;

  // Handshake, issue selection and last-x detection.
  // The first x is issued straight from IDLE on start so the first sample
  // appears two cycles after start.
  always_comb begin
    advance     = ce & ~(out_valid & ~stream.y_ready);
    xfer        = ce & out_valid & stream.y_ready;
    step_eff    = (step_q == '0) ? X_W'(1) : step_q;
    issue_x     = (state == ST_IDLE) ? x0_q : x_q;
    issue_valid = (state == ST_RUN) || ((state == ST_IDLE) && start);
    x_sum       = {1'b0, issue_x} + {1'b0, step_eff};
    issue_last  = (issue_x >= xlast_q) || x_sum[X_W];
    next_x      = issue_last ? x0_q : x_sum[X_W-1:0];
    busy        = (state != ST_IDLE);
    done        = (state == ST_DRAIN) && xfer && out_last && !abort;
  end

  // Control FSM, x counter and configuration capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      m_q     <= '0;
      c_q     <= '0;
      x0_q    <= '0;
      step_q  <= '0;
      xlast_q <= '0;
      mode_q  <= '0;
      x_q     <= '0;
    end else if (ce) begin
      if (abort) begin
        state <= ST_IDLE;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (cfg_load) begin
              m_q     <= cfg_m;
              c_q     <= cfg_c;
              x0_q    <= cfg_x0;
              step_q  <= cfg_xstep;
              xlast_q <= cfg_xlast;
              mode_q  <= cfg_mode;
            end
            if (start) begin
              x_q   <= next_x;
              state <= (issue_last && !mode_q[MODE_CONT]) ? ST_DRAIN : ST_RUN;
            end
          end
          ST_RUN: begin
            if (advance) begin
              x_q <= next_x;
              if (issue_last && !mode_q[MODE_CONT]) state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (xfer && out_last) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  line_gen_mac #(
    .COEF_W (COEF_W),
    .X_W    (X_W),
    .Y_W    (Y_W)
  ) u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .advance   (advance),
    .flush     (abort),
    .sat       (mode_q[MODE_SAT]),
    .m         (m_q),
    .c         (c_q),
    .in_valid  (issue_valid),
    .in_x      (issue_x),
    .in_last   (issue_last),
    .out_valid (out_valid),
    .out_x     (out_x),
    .out_last  (out_last),
    .y         (out_y)
  );

  assign stream.y       = out_y;
  assign stream.x_out   = out_x;
  assign stream.y_valid = out_valid;

endmodule

// File: tb/tb_line_gen.sv
// Self-checking bench for line_gen: a sweep-list model checks every output
// cycle of instance A; directed literal checks pin the model and cover the
// narrow-X instance B.
module tb_line_gen;

  logic        clk = 1'b0;
  logic        rst_n, ce, cfg_load, start_a, start_b, abort, abort_b;
  logic [7:0]  cfg_m, cfg_c;
  logic [15:0] x0_a, step_a, xlast_a;
  logic [7:0]  x0_b, step_b, xlast_b;
  logic [1:0]  cfg_mode;
  logic        busy_a, done_a, busy_b, done_b;
  int unsigned cyc = 0;

  line_gen_if #(.X_W(16), .Y_W(16)) ifa ();
  line_gen_if #(.X_W(8),  .Y_W(32)) ifb ();

  line_gen #(.COEF_W(8), .X_W(16), .Y_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .ce(ce), .cfg_load(cfg_load),
    .cfg_m(cfg_m), .cfg_c(cfg_c), .cfg_x0(x0_a), .cfg_xstep(step_a),
    .cfg_xlast(xlast_a), .cfg_mode(cfg_mode), .start(start_a), .abort(abort),
    .busy(busy_a), .done(done_a), .stream(ifa)
  );

  line_gen #(.COEF_W(8), .X_W(8), .Y_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .ce(ce), .cfg_load(cfg_load),
    .cfg_m(cfg_m), .cfg_c(cfg_c), .cfg_x0(x0_b), .cfg_xstep(step_b),
    .cfg_xlast(xlast_b), .cfg_mode(cfg_mode), .start(start_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .stream(ifb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_q(input string n, input logic [63:0] got[$], input logic [63:0] ex[$]);
    chk({n, "_count"}, 64'(got.size()), 64'(ex.size()));
    foreach (ex[i]) chk(n, (i < got.size()) ? got[i] : 64'hDEAD_DEAD, ex[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- model: one period of the x sweep ----------------
  logic [63:0] mx[$];
  int unsigned midx;
  bit          mcont, msat, mactive;
  logic [63:0] mm, mc;
  bit          exp_done_a;

  function automatic logic [63:0] exp_y(input logic [63:0] x);
    logic [63:0] s;
    s = mm * x + mc;
    if (msat) return (s > 64'd65535) ? 64'd65535 : s;
    return s % 64'd65536;
  endfunction

  task automatic plan(input logic [63:0] x0, input logic [63:0] step,
                      input logic [63:0] xlast, input int unsigned xw);
    logic [63:0] x, st, lim;
    mx.delete();
    st  = (step == 0) ? 64'd1 : step;
    lim = 64'd1 << xw;
    x   = x0;
    for (int i = 0; i < 1000; i++) begin
      mx.push_back(x);
      if (x >= xlast || x + st >= lim) break;
      x = x + st;
    end
  endtask

  // Every cycle: a valid sample must be the next one in the sweep, and done
  // must pulse exactly when the final one-shot sample is taken.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      exp_done_a = 1'b0;
      if (ifa.y_valid) begin
        if (!mactive || midx >= mx.size()) begin
          chk("stream_valid", 64'(ifa.y_valid), 64'd0);
        end else begin
          chk("model_x", 64'(ifa.x_out), mx[midx]);
          chk("model_y", 64'(ifa.y), exp_y(mx[midx]));
          if (ce && ifa.y_ready) begin
            if (!mcont && midx == mx.size() - 1 && !abort) exp_done_a = 1'b1;
            midx++;
            if (mcont && midx == mx.size()) midx = 0;
          end
        end
      end
      chk("model_done", 64'(done_a), 64'(exp_done_a));
    end
  end

  // ---------------- transfer log for literal checks ----------------
  logic [63:0] got_y[$], got_x[$], got_c[$], done_c[$], gotb_x[$], gotb_y[$];
  int nb_done = 0;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ce && ifa.y_valid && ifa.y_ready) begin
        got_y.push_back(64'(ifa.y));
        got_x.push_back(64'(ifa.x_out));
        got_c.push_back(64'(cyc));
      end
      if (done_a) done_c.push_back(64'(cyc));
      if (ce && ifb.y_valid && ifb.y_ready) begin
        gotb_x.push_back(64'(ifb.x_out));
        gotb_y.push_back(64'(ifb.y));
      end
      if (done_b) nb_done++;
    end
  end

  int unsigned t0;
  logic [63:0] ex[$];

  task automatic setup(input logic [7:0] m, input logic [7:0] c, input logic [15:0] x0,
                       input logic [15:0] st, input logic [15:0] xl, input logic [1:0] mode);
    cfg_m = m; cfg_c = c;
    x0_a = x0; step_a = st; xlast_a = xl;
    x0_b = x0[7:0]; step_b = st[7:0]; xlast_b = xl[7:0];
    cfg_mode = mode;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    plan(64'(x0), 64'(st), 64'(xl), 16);
    mm = 64'(m); mc = 64'(c); mcont = mode[0]; msat = mode[1];
    midx = 0; mactive = 1'b1;
  endtask

  task automatic go();
    got_y.delete(); got_x.delete(); got_c.delete(); done_c.delete();
    start_a = 1'b1;
    t0 = cyc;
    tick();
    start_a = 1'b0;
  endtask

  task automatic wait_idle(input string n, input int budget);
    for (int i = 0; i < budget && busy_a; i++) tick();
    chk(n, 64'(busy_a), 64'd0);
  endtask

  task automatic chk_outputs_zero(input string n);
    chk({n, "_y"}, 64'(ifa.y), 64'd0);
    chk({n, "_x"}, 64'(ifa.x_out), 64'd0);
    chk({n, "_valid"}, 64'(ifa.y_valid), 64'd0);
    chk({n, "_busy"}, 64'(busy_a), 64'd0);
    chk({n, "_done"}, 64'(done_a), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b0; cfg_load = 1'b0; start_a = 1'b1; start_b = 1'b0;
    abort = 1'b0; abort_b = 1'b0; cfg_m = '0; cfg_c = '0; cfg_mode = '0;
    x0_a = '0; step_a = '0; xlast_a = '0; x0_b = '0; step_b = '0; xlast_b = '0;
    ifa.y_ready = 1'b1; ifb.y_ready = 1'b1;
    mactive = 1'b0; midx = 0; mcont = 1'b0; msat = 1'b0; mm = '0; mc = '0;

    // Reset held 3 cycles with start high and ce low.
    repeat (3) tick();
    chk_outputs_zero("reset");
    start_a = 1'b0; rst_n = 1'b1; ce = 1'b1;
    tick();

    // One-shot ramp, no backpressure.
    setup(8'd3, 8'd5, 16'd1, 16'd1, 16'd4, 2'b00);
    go();
    wait_idle("oneshot_idle", 20);
    ex = {64'd8, 64'd11, 64'd14, 64'd17};        chk_q("oneshot_y", got_y, ex);
    ex = {64'd1, 64'd2, 64'd3, 64'd4};           chk_q("oneshot_x", got_x, ex);
    ex = {64'(t0 + 2), 64'(t0 + 3), 64'(t0 + 4), 64'(t0 + 5)};
    chk_q("oneshot_cycle", got_c, ex);
    ex = {64'(t0 + 5)};                          chk_q("oneshot_done", done_c, ex);

    // Backpressure on cycles T+3..T+5.
    setup(8'd3, 8'd5, 16'd1, 16'd1, 16'd4, 2'b00);
    go();
    for (int i = 0; i < 20 && busy_a; i++) begin
      ifa.y_ready = !((cyc - t0) >= 3 && (cyc - t0) <= 5);
      if (cyc - t0 == 4) begin
        chk("bp_hold_valid", 64'(ifa.y_valid), 64'd1);
        chk("bp_hold_y", 64'(ifa.y), 64'd11);
      end
      tick();
    end
    ifa.y_ready = 1'b1;
    wait_idle("bp_idle", 5);
    ex = {64'd8, 64'd11, 64'd14, 64'd17};        chk_q("bp_y", got_y, ex);
    ex = {64'(t0 + 2), 64'(t0 + 6), 64'(t0 + 7), 64'(t0 + 8)};
    chk_q("bp_cycle", got_c, ex);

    // Saturate and wrap of 255*300 = 76500 into 16 bits.
    setup(8'd255, 8'd0, 16'd300, 16'd1, 16'd300, 2'b10);
    go();
    wait_idle("sat_idle", 10);
    ex = {64'd65535};                            chk_q("sat_y", got_y, ex);
    setup(8'd255, 8'd0, 16'd300, 16'd1, 16'd300, 2'b00);
    go();
    wait_idle("wrap_idle", 10);
    ex = {64'd10964};                            chk_q("wrap_y", got_y, ex);

    // Zero step behaves as step 1.
    setup(8'd2, 8'd1, 16'd0, 16'd0, 16'd2, 2'b00);
    go();
    wait_idle("step0_idle", 10);
    ex = {64'd1, 64'd3, 64'd5};                  chk_q("step0_y", got_y, ex);

    // ce toggling stretches the same one-shot sequence.
    setup(8'd3, 8'd5, 16'd1, 16'd1, 16'd4, 2'b00);
    go();
    for (int i = 0; i < 40 && busy_a; i++) begin
      ce = ~ce;
      tick();
    end
    ce = 1'b1;
    chk("ce_idle", 64'(busy_a), 64'd0);
    ex = {64'd8, 64'd11, 64'd14, 64'd17};        chk_q("ce_y", got_y, ex);
    chk("ce_done_count", 64'(done_c.size()), 64'd1);

    // Continuous mode then abort.
    setup(8'd1, 8'd0, 16'd2, 16'd3, 16'd7, 2'b01);
    go();
    repeat (10) tick();
    ex = {64'd2, 64'd5, 64'd8, 64'd2, 64'd5, 64'd8};
    for (int i = 0; i < 6; i++)
      chk("cont_x", (i < got_x.size()) ? got_x[i] : 64'hDEAD_DEAD, ex[i]);
    chk("cont_done_count", 64'(done_c.size()), 64'd0);
    chk("cont_busy", 64'(busy_a), 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    mactive = 1'b0;
    chk("abort_valid", 64'(ifa.y_valid), 64'd0);
    chk("abort_busy", 64'(busy_a), 64'd0);

    // abort beats start in IDLE.
    start_a = 1'b1; abort = 1'b1;
    tick();
    start_a = 1'b0; abort = 1'b0;
    chk("abort_prio_busy", 64'(busy_a), 64'd0);
    repeat (3) tick();
    chk("abort_prio_valid", 64'(ifa.y_valid), 64'd0);

    // 8-bit x counter overflow ends the sweep early.
    setup(8'd1, 8'd0, 16'd250, 16'd4, 16'd255, 2'b00);
    mactive = 1'b0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 0; i < 20 && busy_b; i++) tick();
    chk("ovf_idle", 64'(busy_b), 64'd0);
    ex = {64'd250, 64'd254};                     chk_q("ovf_x", gotb_x, ex);
    ex = {64'd250, 64'd254};                     chk_q("ovf_y", gotb_y, ex);
    chk("ovf_done_count", 64'(nb_done), 64'd1);

    // Reset in the middle of a sweep.
    setup(8'd3, 8'd5, 16'd1, 16'd1, 16'd4, 2'b00);
    go();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    mactive = 1'b0;
    chk_outputs_zero("midrst");
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
